// File: rtl/sprite_pkg.sv
// Shared types and default widths for the sprite ROM / palette response path.
package sprite_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int IDX_W_DEF      = 4;
  localparam int TRANSP_IDX_DEF = 0;
  // Wide enough for up to 8 requesters; narrower ids are zero-extended into it.
  localparam int ID_MAX_W       = 3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    rgb12_t              rgb;
    logic                transp;
  } rsp_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr+1, pointer follows each grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_REQ-1:0] valid,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      idx = sum[ID_W-1:0];
      if (enable && !found && valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  // Any grant is also a handshake, since grants only go to valid requesters.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr_reg <= ID_W'(N_REQ - 1);
    end else if (found) begin
      ptr_reg <= grant_id;
    end
  end

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Shares one sprite ROM and palette among N_REQ requesters: RR issue, ROM read,
// palette lookup, then an in-order response FIFO guarded by credits.
module sprite_palette_arbiter
  import sprite_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int IDX_W      = IDX_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TRANSP_IDX = TRANSP_IDX_DEF,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [IDX_W-1:0]        rom_data,
  output logic [IDX_W-1:0]        pal_index,
  input  logic [3:0]              pal_red,
  input  logic [3:0]              pal_green,
  input  logic [3:0]              pal_blue,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [11:0]             rsp_rgb,
  output logic                    rsp_transp
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_slot [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign addr_slot[gi] = req_addr[gi*ADDR_W +: ADDR_W];
  end

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;
  logic              s1_v_reg, s2_v_reg;
  logic [ID_W-1:0]   s1_id_reg, s2_id_reg;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  in_use;
  logic              credit_ok;

  // Every issued request already owns a FIFO slot, so pushes can never overflow.
  assign in_use    = count_reg + CNT_W'(s1_v_reg) + CNT_W'(s2_v_reg);
  assign credit_ok = Reset_n && (in_use < CNT_W'(FIFO_DEPTH));

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .valid    (req_valid),
    .enable   (credit_ok),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_v_reg     <= 1'b0;
      s1_id_reg    <= '0;
      rom_addr_reg <= '0;
      s2_v_reg     <= 1'b0;
      s2_id_reg    <= '0;
    end else begin
      s1_v_reg <= |grant;
      if (|grant) begin
        rom_addr_reg <= addr_slot[grant_id];
        s1_id_reg    <= grant_id;
      end
      s2_v_reg  <= s1_v_reg;
      s2_id_reg <= s1_id_reg;
    end
  end

  assign rom_addr  = rom_addr_reg;
  // The ROM registers its output, so S2 sees the index one cycle after rom_addr.
  assign pal_index = s2_v_reg ? rom_data : '0;

  rsp_entry_t       fifo_mem [FIFO_DEPTH];
  rsp_entry_t       push_entry;
  rsp_entry_t       head;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic             push, pop, full;

  assign push = s2_v_reg;
  assign pop  = rsp_valid && rsp_ready;
  assign full = (count_reg == CNT_W'(FIFO_DEPTH));

  always_comb begin
    push_entry        = '0;
    push_entry.id     = ID_MAX_W'(s2_id_reg);
    push_entry.rgb    = '{r: pal_red, g: pal_green, b: pal_blue};
    push_entry.transp = (rom_data == IDX_W'(TRANSP_IDX));
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rsp_valid  = (count_reg != '0);
  assign head       = rsp_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign rsp_id     = ID_W'(head.id);
  assign rsp_rgb    = head.rgb;
  assign rsp_transp = head.transp;

  assert property (@(posedge Clk) disable iff (!Reset_n) !(push && full));

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Bench for sprite_palette_arbiter: ROM/palette models, response scoreboard,
// vector table for round-robin grants, hand sequences for latency/backpressure/reset.
module tb_sprite_palette_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [47:0] req_addr = '0;
  logic [3:0]  req_ready;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data = '0;
  logic [3:0]  pal_index, pal_red, pal_green, pal_blue;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [11:0] rsp_rgb;
  logic        rsp_transp;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;

  sprite_palette_arbiter dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pal_index  (pal_index),
    .pal_red    (pal_red),
    .pal_green  (pal_green),
    .pal_blue   (pal_blue),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_rgb    (rsp_rgb),
    .rsp_transp (rsp_transp)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_f(input logic [11:0] a);
    return a[3:0] + a[7:4] + a[11:8] + 4'd1;
  endfunction

  function automatic logic [11:0] pal_f(input logic [3:0] i);
    return {i, ~i, i ^ 4'hA};
  endfunction

  always @(posedge Clk) rom_data <= rom_f(rom_addr);
  assign {pal_red, pal_green, pal_blue} = pal_f(pal_index);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] rgb;
    logic        transp;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  // Handshakes push the expected response; consumer pops are compared in order.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      sb_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        $display("rsp %0d: id=%0d rgb=%03h transp=%0b", n_rsp, rsp_id, rsp_rgb, rsp_transp);
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          check("rsp_order", 32'({rsp_id, rsp_rgb, rsp_transp}), 32'(sb_e));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_e.id     = 2'(i);
          sb_e.rgb    = pal_f(rom_f(req_addr[i*12 +: 12]));
          sb_e.transp = (rom_f(req_addr[i*12 +: 12]) == 4'd0);
          sb_q.push_back(sb_e);
        end
      end
    end
  end

  task automatic cyc(input logic rst_n, input logic [3:0] v, input logic rr);
    @(posedge Clk);
    #1;
    Reset_n   = rst_n;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < 4; i++) req_addr[i*12 +: 12] = 12'($urandom);
    #1;
  endtask

  task automatic single_req(input int id, input logic [11:0] addr, input logic [3:0] exp_idx);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    @(posedge Clk);
    #1;
    req_valid = oh;
    req_addr[id*12 +: 12] = addr;
    rsp_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'(oh));
    @(posedge Clk);
    #1;
    req_valid = '0;
    #1;
    check("single_rom_addr", 32'(rom_addr), 32'(addr));
    @(posedge Clk);
    #2;
    check("single_pal_index", 32'(pal_index), 32'(exp_idx));
    @(posedge Clk);
    #2;
    check("single_rsp", 32'({rsp_valid, rsp_id, rsp_rgb, rsp_transp}),
          32'({1'b1, 2'(id), pal_f(exp_idx), exp_idx == 4'd0}));
  endtask

  typedef struct {
    logic [3:0] v;
    logic       rr;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs[12];
  int   grants;
  int   resumed;
  logic [14:0] snap;

  initial begin
    vecs[0]  = '{4'b1111, 1'b1, 4'b0010};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0100};
    vecs[2]  = '{4'b1111, 1'b1, 4'b1000};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0001};
    vecs[4]  = '{4'b0000, 1'b1, 4'b0000};
    vecs[5]  = '{4'b1001, 1'b1, 4'b1000};
    vecs[6]  = '{4'b1001, 1'b1, 4'b0001};
    vecs[7]  = '{4'b0100, 1'b1, 4'b0100};
    vecs[8]  = '{4'b0100, 1'b1, 4'b0100};
    vecs[9]  = '{4'b0011, 1'b1, 4'b0001};
    vecs[10] = '{4'b0011, 1'b1, 4'b0010};
    vecs[11] = '{4'b1010, 1'b1, 4'b1000};

    // Reset held with every requester asking
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 4'hF, 1'b0);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check("reset_outputs", 32'({rom_addr, pal_index, rsp_id, rsp_rgb, rsp_transp}), 32'd0);
    cyc(1'b1, 4'hF, 1'b1);
    check("first_grant", 32'(req_ready), 32'b0001);

    // Round-robin table
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, vecs[i].v, vecs[i].rr);
      check($sformatf("rr_vec%0d", i), 32'(req_ready), 32'(vecs[i].exp_ready));
    end
    for (int c = 0; c < 5; c++) cyc(1'b1, 4'h0, 1'b1);

    // Latency and transparency
    single_req(2, 12'h123, 4'h7);
    single_req(1, 12'h00F, 4'h0);
    single_req(3, 12'h000, 4'h1);
    for (int c = 0; c < 2; c++) cyc(1'b1, 4'h0, 1'b1);

    // Backpressure: credits stop issue at FIFO depth
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 4'hF, 1'b0);
      if (req_ready != 4'b0000) grants++;
    end
    check("bp_grant_count", 32'(grants), 32'd4);
    check("bp_ready_blocked", 32'(req_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    snap = {rsp_id, rsp_rgb, rsp_transp};
    cyc(1'b1, 4'hF, 1'b0);
    check("bp_head_stable", 32'({rsp_id, rsp_rgb, rsp_transp}), 32'(snap));
    resumed = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 4'hF, 1'b1);
      if (req_ready != 4'b0000) resumed++;
    end
    check("bp_resume", 32'(resumed > 0), 32'd1);
    for (int c = 0; c < 6; c++) cyc(1'b1, 4'h0, 1'b1);
    check("bp_drained", 32'(sb_q.size()), 32'd0);

    // Reset pulse with two entries queued and two in flight
    for (int c = 0; c < 4; c++) cyc(1'b1, 4'hF, 1'b0);
    cyc(1'b0, 4'hF, 1'b0);
    cyc(1'b1, 4'hF, 1'b1);
    check("midrst_rsp_valid0", 32'(rsp_valid), 32'd0);
    check("midrst_first_grant", 32'(req_ready), 32'b0001);
    cyc(1'b1, 4'h0, 1'b1);
    check("midrst_rsp_valid1", 32'(rsp_valid), 32'd0);
    cyc(1'b1, 4'h0, 1'b1);
    check("midrst_rsp_valid2", 32'(rsp_valid), 32'd0);
    for (int c = 0; c < 5; c++) cyc(1'b1, 4'h0, 1'b1);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_rsp_count", 32'(n_rsp > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
